lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Parametrised load/store unit controller for the RV32I pipeline MEM stage, superseding the purely combinational memory-control decode. It decodes load/store instructions and runs a multi-cycle req/ack transaction on the data-memory bus. It generates byte-lane strobes and lane-replicated write data, then sign- or zero-extends load data. It stalls the pipeline while an access is in flight and reports misaligned, illegal-size and bus-timeout faults.

## Interface
- ADDR_W, 32, byte-address width (≥3)
- TIMEOUT, 15, max REQ cycles without ack before bus fault; 0 disables timeout
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  MEM-stage instruction valid
- opcode  in  7  instruction opcode (LOAD 7'b0000011, STORE 7'b0100011)
- funct3  in  3  width/sign field
- flush  in  1  squash current MEM-stage instruction
- addr  in  ADDR_W  effective byte address
- wdata  in  32  store data (rs2)
- access_size  out  2  comb: 00 word, 01 half, 10 byte, 11 improper/non-mem
- stall  out  1  comb: hold pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid with done
- fault  out  2  valid with done: 00 none, 01 misaligned, 10 bus timeout, 11 illegal size
- mem_req  out  1  bus request (registered)
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  bus completion; read data valid same cycle
- mem_rdata  in  32  bus read data

## Operation
- mem_op = valid & !flush & (opcode==LOAD | opcode==STORE). access_size from funct3[1:0] (00 byte, 01 half, 10 word, 11 improper) when load/store, else 11.
- Illegal: funct3[1:0]==11, or store with funct3[2]==1. Misaligned: half with addr[0]==1, word with addr[1:0]!=0. Illegal takes priority over misaligned.
- FSM states IDLE, REQ, RESP.
- IDLE: on mem_op, latch op, funct3[2] and addr[1:0]. If illegal/misaligned, go to RESP with the fault and no bus access. Otherwise drive the bus registers and go to REQ.
- Lanes: byte be=4'b0001<<addr[1:0], wdata {4{wdata[7:0]}}; half be=4'b0011<<addr[1:0], wdata {2{wdata[15:0]}}; word be=4'b1111. Loads drive the same be pattern with mem_we=0.
- REQ: mem_req and all bus outputs are held stable until mem_ack. A request is never retracted except on timeout or reset. On ack, capture mem_rdata and go to RESP. On timeout, drop mem_req, set fault=10 and go to RESP.
- Timeout counter: width $clog2(TIMEOUT+1). Cleared on entry to REQ, incremented each REQ cycle without ack. Timeout fires when count==TIMEOUT and !mem_ack; ack in that cycle wins.
- RESP: done=1 for one cycle, then unconditionally return to IDLE. The request held on the inputs during RESP is not re-accepted.
- Load result: select byte/half at the latched addr[1:0]. funct3[2]=0 sign-extends, 1 zero-extends; word is passed through. rdata=0 on fault or store.
- stall = (IDLE & mem_op) | REQ. It is 0 in RESP, so the pipeline advances at the RESP edge.
- Flush in REQ/RESP: the bus transaction still completes (stores are not cancellable). A flushed load or faulted access drives done=1 with rdata=0. For a flushed load, fault=00; a flush-marked transaction never reports a fault.
- Non-memory ops and flush in IDLE: no state change, stall=0, no bus activity.

## Timing
- Reset (async): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, done=0, rdata=0, fault=00, counter=0. Asserting reset mid-REQ drops mem_req immediately; the bus tolerates this.
- Accept at edge t0; mem_req high from t1. Ack at t1+k gives RESP/done at t1+k+1.
- Minimum bus latency is 2 cycles (k=0); stall is high t0..t1+k.
- Fault without bus access: stall for 1 cycle, done the next cycle.
- Timeout: mem_req high for exactly TIMEOUT+1 cycles, then done with fault=10 on the following cycle.
- done, rdata and fault are registered; stall and access_size are combinational.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, stall 4 cycles, done fault=00.
- SB addr=0x103 wdata=0x000000A5 -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x102, mem_rdata=0x0080FF00, immediate ack -> rdata=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x102 -> 0x00000080. LHU addr=0x100 -> 0x0000FF00.
- LW addr=0x101 -> no mem_req, done next cycle fault=01. SH with funct3=3'b101 -> fault=11.
- TIMEOUT=3, no ack -> mem_req high 4 cycles, drop, done fault=10. Ack on 4th REQ cycle -> fault=00.
- Load then flush during REQ, ack later -> done with rdata=0, fault=00. Reset mid-REQ -> mem_req=0 same cycle, state IDLE.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller for the RV32I MEM stage: decodes loads and stores,
// runs one req/ack data-bus transaction at a time and extends load data.
module lsu_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [1:0]        o_access_size,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_fault,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

  // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] f_lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   f_lane_be = 4'b0001 << lane;
      2'b01:   f_lane_be = 4'b0011 << lane;
      default: f_lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   f_lane_wdata = {4{data[7:0]}};
      2'b01:   f_lane_wdata = {2{data[15:0]}};
      default: f_lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] data);
    logic [31:0] sh;
    sh = data >> {lane, 3'b000};
    case (size)
      2'b00:   f_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: f_extend = data;
    endcase
  endfunction

  state_t            r_state;
  logic              r_is_store;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic              r_flushed;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic [31:0]       r_rdata;
  logic [1:0]        r_fault;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_ls;
  logic       w_mem_op;
  logic       w_illegal;
  logic       w_misaligned;
  logic       w_timeout;
  logic       w_flush_mark;
  logic [1:0] w_access_size;

  assign w_is_load  = (i_opcode == OP_LOAD);
  assign w_is_store = (i_opcode == OP_STORE);
  assign w_is_ls    = w_is_load | w_is_store;
  assign w_mem_op   = i_valid & ~i_flush & w_is_ls;

  assign w_illegal    = (i_funct3[1:0] == 2'b11) | (w_is_store & i_funct3[2]);
  assign w_misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                        ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));

  // An ack arriving in the last allowed cycle beats the timeout.
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_MAX) && !i_mem_ack;
  assign w_flush_mark = r_flushed | i_flush;

  always_comb begin
    w_access_size = 2'b11;
    if (w_is_ls) begin
      case (i_funct3[1:0])
        2'b00:   w_access_size = 2'b10;
        2'b01:   w_access_size = 2'b01;
        2'b10:   w_access_size = 2'b00;
        default: w_access_size = 2'b11;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_is_store  <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_flushed   <= 1'b0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_rdata     <= 32'd0;
      r_fault     <= FLT_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_rdata <= 32'd0;
          r_fault <= FLT_NONE;
          if (w_mem_op) begin
            r_is_store <= w_is_store;
            r_unsigned <= i_funct3[2];
            r_size     <= i_funct3[1:0];
            r_lane     <= i_addr[1:0];
            r_flushed  <= 1'b0;
            r_cnt      <= '0;
            if (w_illegal || w_misaligned) begin
              // Faulted access skips the bus and reports straight away.
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_fault <= w_illegal ? FLT_ILLEGAL : FLT_MISALIGN;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              r_mem_be    <= f_lane_be(i_funct3[1:0], i_addr[1:0]);
              r_mem_wdata <= f_lane_wdata(i_funct3[1:0], i_wdata);
            end
          end
        end
        S_REQ: begin
          if (i_flush) begin
            r_flushed <= 1'b1;
          end
          if (i_mem_ack) begin
            r_state   <= S_RESP;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_fault   <= FLT_NONE;
            r_rdata   <= (r_is_store || w_flush_mark) ? 32'd0
                         : f_extend(r_size, r_unsigned, r_lane, i_mem_rdata);
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_rdata   <= 32'd0;
            r_fault   <= w_flush_mark ? FLT_NONE : FLT_TIMEOUT;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rdata <= 32'd0;
          r_fault <= FLT_NONE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_access_size = w_access_size;
  assign o_stall       = ((r_state == S_IDLE) & w_mem_op) | (r_state == S_REQ);
  assign o_done        = r_done;
  assign o_rdata       = r_rdata;
  assign o_fault       = r_fault;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_be      = r_mem_be;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized transactions
// compared every cycle against a transaction-level expectation timeline.
module tb_lsu_ctrl;
  localparam int ADDR_W = 32;
  localparam int TO     = 3;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              flush;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        access_size;
  logic              stall;
  logic              done;
  logic [31:0]       rdata;
  logic [1:0]        fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_opcode(opcode), .i_funct3(funct3),
    .i_flush(flush), .i_addr(addr), .i_wdata(wdata), .o_access_size(access_size),
    .o_stall(stall), .o_done(done), .o_rdata(rdata), .o_fault(fault),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  logic              chk_en;
  logic              e_stall, e_req, e_done, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [3:0]        e_be;
  logic [31:0]       e_wd, e_rdata;
  logic [1:0]        e_fault;

  int                n_stall, n_req, n_done;
  logic [31:0]       last_rdata;
  logic [1:0]        last_fault;
  logic [3:0]        seen_be;
  logic [31:0]       seen_wdata;
  logic [ADDR_W-1:0] seen_addr;
  logic              seen_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_asz(input logic [6:0] op, input logic [2:0] f3);
    if (op != LOAD && op != STORE) return 2'b11;
    case (f3[1:0])
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      2'b10:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("done", 32'(done), 32'(e_done));
      if (e_done) begin
        chk("rdata", rdata, e_rdata);
        chk("fault", 32'(fault), 32'(e_fault));
      end
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wd);
      end
      if (valid && !flush)
        chk("access_size", 32'(access_size), 32'(m_asz(opcode, funct3)));
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        seen_be    = mem_be;
        seen_wdata = mem_wdata;
        seen_addr  = mem_addr;
        seen_we    = mem_we;
      end
      if (done) begin
        n_done++;
        last_rdata = rdata;
        last_fault = fault;
      end
    end
  end

  // One instruction presented to the MEM stage; ack_k > TO means the bus never acks.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_k, input logic [31:0] rd,
                         input int flush_at, input logic fl0);
    logic        memop, illegal, misal, timed_out, flushed;
    int          nb, lane, n_bus;
    logic [31:0] ld, ex_wd, ex_rdata;
    logic [3:0]  ex_be;
    logic [1:0]  ex_fault;
    n_stall = 0; n_req = 0; n_done = 0;
    memop   = ((op == LOAD) || (op == STORE)) && !fl0;
    nb      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lane    = int'(a & 32'd3);
    illegal = (f3[1:0] == 2'b11) || (op == STORE && f3[2]);
    misal   = !illegal && ((lane % nb) != 0);
    ex_be   = 4'(((1 << nb) - 1) << lane);
    for (int i = 0; i < 4; i++) ex_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    ld = rd >> (8 * lane);
    if (nb == 1) begin
      ld = ld & 32'hFF;
      if (!f3[2] && ld[7]) ld = ld - 32'h100;
    end else if (nb == 2) begin
      ld = ld & 32'hFFFF;
      if (!f3[2] && ld[15]) ld = ld - 32'h10000;
    end
    timed_out = ack_k > TO;
    n_bus     = timed_out ? TO + 1 : ack_k + 1;
    flushed   = (flush_at > 0) && (flush_at <= n_bus);
    ex_fault  = illegal ? 2'b11 : misal ? 2'b01 : (timed_out && !flushed) ? 2'b10 : 2'b00;
    ex_rdata  = (op == STORE || flushed || timed_out) ? 32'd0 : ld;

    @(posedge clk); #1;
    valid = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd; flush = fl0;
    mem_ack = 1'b0; mem_rdata = $urandom;
    e_stall = memop; e_req = 1'b0; e_done = 1'b0;
    if (!memop) begin
      @(posedge clk); #1;
      valid = 1'b0; flush = 1'b0; e_stall = 1'b0;
    end else if (illegal || misal) begin
      @(posedge clk); #1;
      e_stall = 1'b0; e_done = 1'b1; e_rdata = 32'd0; e_fault = ex_fault;
      @(posedge clk); #1;
      valid = 1'b0; e_done = 1'b0;
    end else begin
      e_addr = a & ~32'd3; e_be = ex_be; e_wd = ex_wd; e_we = (op == STORE);
      for (int c = 1; c <= n_bus; c++) begin
        @(posedge clk); #1;
        e_req = 1'b1; e_stall = 1'b1; e_done = 1'b0;
        flush     = (c == flush_at);
        mem_ack   = !timed_out && (c == n_bus);
        mem_rdata = mem_ack ? rd : $urandom;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; flush = 1'b0; mem_rdata = $urandom;
      e_req = 1'b0; e_stall = 1'b0; e_done = 1'b1; e_rdata = ex_rdata; e_fault = ex_fault;
      @(posedge clk); #1;
      valid = 1'b0; e_done = 1'b0;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = '0;
    wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0; chk_en = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0; e_we = 1'b0; e_addr = '0; e_be = 4'd0;
    e_wd = 32'd0; e_rdata = 32'd0; e_fault = 2'd0;
    n_stall = 0; n_req = 0; n_done = 0; last_rdata = 32'd0; last_fault = 2'd0;
    seen_be = 4'd0; seen_wdata = 32'd0; seen_addr = '0; seen_we = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_txn(STORE, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'd0, 0, 1'b0);
    chk("SW be", 32'(seen_be), 32'hF);
    chk("SW wdata", seen_wdata, 32'hDEADBEEF);
    chk("SW we", 32'(seen_we), 32'd1);
    chk("SW stall cycles", 32'(n_stall), 32'd4);
    chk("SW done count", 32'(n_done), 32'd1);
    chk("SW fault", 32'(last_fault), 32'd0);

    run_txn(STORE, 3'b000, 32'h103, 32'h000000A5, 0, 32'd0, 0, 1'b0);
    chk("SB addr", 32'(seen_addr), 32'h100);
    chk("SB be", 32'(seen_be), 32'h8);
    chk("SB wdata", seen_wdata, 32'hA5A5A5A5);

    run_txn(LOAD, 3'b000, 32'h102, 32'd0, 0, 32'h0080FF00, 0, 1'b0);
    chk("LB rdata", last_rdata, 32'hFFFFFF80);
    chk("LB stall cycles", 32'(n_stall), 32'd2);
    run_txn(LOAD, 3'b100, 32'h102, 32'd0, 0, 32'h0080FF00, 0, 1'b0);
    chk("LBU rdata", last_rdata, 32'h00000080);
    run_txn(LOAD, 3'b001, 32'h102, 32'd0, 0, 32'h0080FF00, 0, 1'b0);
    chk("LH rdata", last_rdata, 32'h00000080);
    run_txn(LOAD, 3'b101, 32'h100, 32'd0, 0, 32'h0080FF00, 0, 1'b0);
    chk("LHU rdata", last_rdata, 32'h0000FF00);

    run_txn(LOAD, 3'b010, 32'h101, 32'd0, 0, 32'd0, 0, 1'b0);
    chk("LW misaligned req cycles", 32'(n_req), 32'd0);
    chk("LW misaligned fault", 32'(last_fault), 32'd1);
    chk("LW misaligned stall cycles", 32'(n_stall), 32'd1);
    run_txn(STORE, 3'b101, 32'h100, 32'h1234, 0, 32'd0, 0, 1'b0);
    chk("SH illegal fault", 32'(last_fault), 32'd3);

    run_txn(LOAD, 3'b010, 32'h100, 32'd0, 99, 32'd0, 0, 1'b0);
    chk("timeout req cycles", 32'(n_req), 32'd4);
    chk("timeout fault", 32'(last_fault), 32'd2);
    run_txn(LOAD, 3'b010, 32'h104, 32'd0, 3, 32'h12345678, 0, 1'b0);
    chk("late ack req cycles", 32'(n_req), 32'd4);
    chk("late ack fault", 32'(last_fault), 32'd0);
    chk("late ack rdata", last_rdata, 32'h12345678);

    run_txn(LOAD, 3'b010, 32'h108, 32'd0, 2, 32'hCAFEF00D, 1, 1'b0);
    chk("flushed load rdata", last_rdata, 32'd0);
    chk("flushed load fault", 32'(last_fault), 32'd0);
    chk("flushed load done count", 32'(n_done), 32'd1);

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    chk_en = 1'b0;
    valid = 1'b1; opcode = LOAD; funct3 = 3'b010; addr = 32'h200; flush = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2; rst = 1'b1;
    #1;
    chk("mid-REQ reset mem_req", 32'(mem_req), 32'd0);
    chk("mid-REQ reset done", 32'(done), 32'd0);
    valid = 1'b0;
    #1;
    chk("mid-REQ reset stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0;
    chk_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic [6:0]  op;
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? LOAD : (sel < 8) ? STORE : 7'($urandom_range(0, 127));
      a   = $urandom & 32'h0000FFFC;
      if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
      run_txn(op, 3'($urandom_range(0, 7)), a, $urandom, int'($urandom_range(0, 5)), $urandom,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0,
              $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
